// File: rtl/sdram_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sdram_burst_scheduler
// Purpose  : Round-robin burst scheduler for the SDRAM multi-port front end.
//            Keeps per-channel address / wrap-limit / burst-length registers
//            for NUM_WR write FIFOs and NUM_RD read FIFOs, selects one
//            eligible channel (class order set by READ_FIRST, round-robin
//            inside a class) and issues a single burst command per cycle of
//            IDLE -> ISSUE -> BUSY -> UPDATE.
// Ports    : i_clk, i_reset             clock, synchronous active-high reset
//            i_wr_level/start/max/len   write-channel FIFO level and config
//            i_wr_load                  per-channel config reload (write)
//            i_rd_level/start/max/len   read-channel FIFO level and config
//            i_rd_load                  per-channel config reload (read)
//            o_cmd_valid/i_cmd_ready    burst command handshake
//            o_cmd_write/addr/len       burst command payload
//            o_wr_grant/o_rd_grant      one-hot active channel
//            i_cmd_done                 burst finished pulse
// Revision : 1.0  initial release
// ============================================================================
module sdram_burst_scheduler #(
  parameter int ASIZE      = 23,
  parameter int LSIZE      = 9,
  parameter int NUM_WR     = 2,
  parameter int NUM_RD     = 2,
  parameter int FIFO_DEPTH = 512,
  parameter int READ_FIRST = 0
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NUM_WR*LSIZE-1:0] i_wr_level,
  input  logic [NUM_WR*ASIZE-1:0] i_wr_start,
  input  logic [NUM_WR*ASIZE-1:0] i_wr_max,
  input  logic [NUM_WR*LSIZE-1:0] i_wr_len,
  input  logic [NUM_WR-1:0]       i_wr_load,
  input  logic [NUM_RD*LSIZE-1:0] i_rd_level,
  input  logic [NUM_RD*ASIZE-1:0] i_rd_start,
  input  logic [NUM_RD*ASIZE-1:0] i_rd_max,
  input  logic [NUM_RD*LSIZE-1:0] i_rd_len,
  input  logic [NUM_RD-1:0]       i_rd_load,
  output logic                    o_cmd_valid,
  input  logic                    i_cmd_ready,
  output logic                    o_cmd_write,
  output logic [ASIZE-1:0]        o_cmd_addr,
  output logic [LSIZE-1:0]        o_cmd_len,
  output logic [NUM_WR-1:0]       o_wr_grant,
  output logic [NUM_RD-1:0]       o_rd_grant,
  input  logic                    i_cmd_done
);

  localparam int c_WPW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam int c_RPW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam logic [c_WPW:0] c_NWR   = (c_WPW+1)'(NUM_WR);
  localparam logic [c_RPW:0] c_NRD   = (c_RPW+1)'(NUM_RD);
  localparam logic [LSIZE:0] c_DEPTH = (LSIZE+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_BUSY   = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [NUM_WR-1:0] r_wr_grant;
  logic [NUM_RD-1:0] r_rd_grant;
  logic              r_cmd_write;
  logic [ASIZE-1:0]  r_cmd_addr;
  logic [LSIZE-1:0]  r_cmd_len;
  logic [c_WPW-1:0]  r_wr_ptr;
  logic [c_RPW-1:0]  r_rd_ptr;

  logic [ASIZE-1:0]  w_wr_addr [NUM_WR];
  logic [LSIZE-1:0]  w_wr_len  [NUM_WR];
  logic [ASIZE-1:0]  w_rd_addr [NUM_RD];
  logic [LSIZE-1:0]  w_rd_len  [NUM_RD];
  logic [NUM_WR-1:0] w_wr_elig;
  logic [NUM_RD-1:0] w_rd_elig;

  logic              w_wr_found;
  logic              w_rd_found;
  logic [c_WPW-1:0]  w_wr_pick;
  logic [c_RPW-1:0]  w_rd_pick;
  logic [c_WPW:0]    w_wr_inc;
  logic [c_RPW:0]    w_rd_inc;
  logic [c_WPW-1:0]  w_wr_ptr_nxt;
  logic [c_RPW-1:0]  w_rd_ptr_nxt;
  logic              w_any;
  logic              w_take_wr;
  logic              w_advance;

  // Burst completion: the granted channel's address moves on this edge, so a
  // LOAD arriving together with CMD_DONE overrides the advance.
  assign w_advance = (r_state == S_BUSY) && i_cmd_done;

  // --------------------------------------------------------------------------
  // Per-channel address / wrap / length registers
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_WR; i++) begin : g_wr
    logic [ASIZE-1:0] r_addr;
    logic [ASIZE-1:0] r_max;
    logic [LSIZE-1:0] r_len;
    logic [LSIZE-1:0] w_level;
    logic [ASIZE-1:0] w_start;
    logic [ASIZE:0]   w_sum;

    assign w_level = i_wr_level[i*LSIZE +: LSIZE];
    assign w_start = i_wr_start[i*ASIZE +: ASIZE];
    assign w_sum   = {1'b0, r_addr} + {{(ASIZE+1-LSIZE){1'b0}}, r_len};

    assign w_wr_addr[i] = r_addr;
    assign w_wr_len[i]  = r_len;
    assign w_wr_elig[i] = (r_len != '0) && ({1'b0, w_level} >= {1'b0, r_len})
                          && !i_wr_load[i];

    always_ff @(posedge i_clk) begin
      if (i_reset || i_wr_load[i]) begin
        r_addr <= w_start;
        r_max  <= i_wr_max[i*ASIZE +: ASIZE];
        r_len  <= i_wr_len[i*LSIZE +: LSIZE];
      end else if (w_advance && r_wr_grant[i]) begin
        // Landing exactly on the limit also wraps.
        r_addr <= (w_sum >= {1'b0, r_max}) ? w_start : w_sum[ASIZE-1:0];
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ASIZE-1:0] r_addr;
    logic [ASIZE-1:0] r_max;
    logic [LSIZE-1:0] r_len;
    logic [LSIZE-1:0] w_level;
    logic [ASIZE-1:0] w_start;
    logic [ASIZE:0]   w_sum;
    logic [LSIZE:0]   w_room;

    assign w_level = i_rd_level[j*LSIZE +: LSIZE];
    assign w_start = i_rd_start[j*ASIZE +: ASIZE];
    assign w_sum   = {1'b0, r_addr} + {{(ASIZE+1-LSIZE){1'b0}}, r_len};
    assign w_room  = c_DEPTH - {1'b0, r_len};

    assign w_rd_addr[j] = r_addr;
    assign w_rd_len[j]  = r_len;
    // A length larger than the FIFO can never fit; guard the subtraction.
    assign w_rd_elig[j] = (r_len != '0) && ({1'b0, r_len} <= c_DEPTH)
                          && ({1'b0, w_level} <= w_room) && !i_rd_load[j];

    always_ff @(posedge i_clk) begin
      if (i_reset || i_rd_load[j]) begin
        r_addr <= w_start;
        r_max  <= i_rd_max[j*ASIZE +: ASIZE];
        r_len  <= i_rd_len[j*LSIZE +: LSIZE];
      end else if (w_advance && r_rd_grant[j]) begin
        r_addr <= (w_sum >= {1'b0, r_max}) ? w_start : w_sum[ASIZE-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round-robin search: first eligible channel at or after the pointer
  // --------------------------------------------------------------------------
  always_comb begin
    logic [c_WPW:0] w_idx;
    w_wr_found = 1'b0;
    w_wr_pick  = '0;
    w_idx      = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      w_idx = {1'b0, r_wr_ptr} + (c_WPW+1)'(k);
      if (w_idx >= c_NWR) w_idx = w_idx - c_NWR;
      if (!w_wr_found && w_wr_elig[w_idx[c_WPW-1:0]]) begin
        w_wr_found = 1'b1;
        w_wr_pick  = w_idx[c_WPW-1:0];
      end
    end
  end

  always_comb begin
    logic [c_RPW:0] w_idx;
    w_rd_found = 1'b0;
    w_rd_pick  = '0;
    w_idx      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      w_idx = {1'b0, r_rd_ptr} + (c_RPW+1)'(k);
      if (w_idx >= c_NRD) w_idx = w_idx - c_NRD;
      if (!w_rd_found && w_rd_elig[w_idx[c_RPW-1:0]]) begin
        w_rd_found = 1'b1;
        w_rd_pick  = w_idx[c_RPW-1:0];
      end
    end
  end

  assign w_wr_inc     = {1'b0, w_wr_pick} + (c_WPW+1)'(1);
  assign w_rd_inc     = {1'b0, w_rd_pick} + (c_RPW+1)'(1);
  assign w_wr_ptr_nxt = (w_wr_inc >= c_NWR) ? '0 : w_wr_inc[c_WPW-1:0];
  assign w_rd_ptr_nxt = (w_rd_inc >= c_NRD) ? '0 : w_rd_inc[c_RPW-1:0];

  assign w_any     = w_wr_found || w_rd_found;
  assign w_take_wr = (READ_FIRST != 0) ? (w_wr_found && !w_rd_found) : w_wr_found;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any)       w_state_nxt = S_ISSUE;
      S_ISSUE:  if (i_cmd_ready) w_state_nxt = S_BUSY;
      S_BUSY:   if (i_cmd_done)  w_state_nxt = S_UPDATE;
      S_UPDATE:                  w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Grant / command registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_grant  <= '0;
      r_rd_grant  <= '0;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_len   <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            if (w_take_wr) begin
              r_wr_grant  <= (NUM_WR)'(1) << w_wr_pick;
              r_cmd_write <= 1'b1;
              r_cmd_addr  <= w_wr_addr[w_wr_pick];
              r_cmd_len   <= w_wr_len[w_wr_pick];
              r_wr_ptr    <= w_wr_ptr_nxt;
            end else begin
              r_rd_grant  <= (NUM_RD)'(1) << w_rd_pick;
              r_cmd_write <= 1'b0;
              r_cmd_addr  <= w_rd_addr[w_rd_pick];
              r_cmd_len   <= w_rd_len[w_rd_pick];
              r_rd_ptr    <= w_rd_ptr_nxt;
            end
          end
        end
        S_BUSY: begin
          if (i_cmd_done) begin
            r_wr_grant <= '0;
            r_rd_grant <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cmd_valid = (r_state == S_ISSUE);
  assign o_cmd_write = r_cmd_write;
  assign o_cmd_addr  = r_cmd_addr;
  assign o_cmd_len   = r_cmd_len;
  assign o_wr_grant  = r_wr_grant;
  assign o_rd_grant  = r_rd_grant;

endmodule
`default_nettype wire

// File: tb/tb_sdram_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_burst_scheduler
// Purpose  : Self-checking bench for sdram_burst_scheduler. A channel-level
//            model (per-channel address/limit/length, round-robin pointers)
//            predicts every issued command; directed scenarios add literal
//            expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_sdram_burst_scheduler;

  localparam int ASIZE      = 23;
  localparam int LSIZE      = 9;
  localparam int NUM_WR     = 2;
  localparam int NUM_RD     = 2;
  localparam int FIFO_DEPTH = 512;
  localparam int READ_FIRST = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [LSIZE-1:0] b_wr_level [NUM_WR];
  logic [ASIZE-1:0] b_wr_start [NUM_WR];
  logic [ASIZE-1:0] b_wr_max   [NUM_WR];
  logic [LSIZE-1:0] b_wr_len   [NUM_WR];
  logic [NUM_WR-1:0] b_wr_load;
  logic [LSIZE-1:0] b_rd_level [NUM_RD];
  logic [ASIZE-1:0] b_rd_start [NUM_RD];
  logic [ASIZE-1:0] b_rd_max   [NUM_RD];
  logic [LSIZE-1:0] b_rd_len   [NUM_RD];
  logic [NUM_RD-1:0] b_rd_load;

  logic [NUM_WR*LSIZE-1:0] wr_level, wr_len;
  logic [NUM_WR*ASIZE-1:0] wr_start, wr_max;
  logic [NUM_RD*LSIZE-1:0] rd_level, rd_len;
  logic [NUM_RD*ASIZE-1:0] rd_start, rd_max;

  logic              cmd_ready = 1'b0;
  logic              cmd_done  = 1'b0;
  logic              cmd_valid, cmd_write;
  logic [ASIZE-1:0]  cmd_addr;
  logic [LSIZE-1:0]  cmd_len;
  logic [NUM_WR-1:0] wr_grant;
  logic [NUM_RD-1:0] rd_grant;

  always_comb begin
    for (int i = 0; i < NUM_WR; i++) begin
      wr_level[i*LSIZE +: LSIZE] = b_wr_level[i];
      wr_len[i*LSIZE +: LSIZE]   = b_wr_len[i];
      wr_start[i*ASIZE +: ASIZE] = b_wr_start[i];
      wr_max[i*ASIZE +: ASIZE]   = b_wr_max[i];
    end
    for (int j = 0; j < NUM_RD; j++) begin
      rd_level[j*LSIZE +: LSIZE] = b_rd_level[j];
      rd_len[j*LSIZE +: LSIZE]   = b_rd_len[j];
      rd_start[j*ASIZE +: ASIZE] = b_rd_start[j];
      rd_max[j*ASIZE +: ASIZE]   = b_rd_max[j];
    end
  end

  sdram_burst_scheduler #(
    .ASIZE(ASIZE), .LSIZE(LSIZE), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD),
    .FIFO_DEPTH(FIFO_DEPTH), .READ_FIRST(READ_FIRST)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wr_level(wr_level), .i_wr_start(wr_start), .i_wr_max(wr_max),
    .i_wr_len(wr_len), .i_wr_load(b_wr_load),
    .i_rd_level(rd_level), .i_rd_start(rd_start), .i_rd_max(rd_max),
    .i_rd_len(rd_len), .i_rd_load(b_rd_load),
    .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd_write(cmd_write),
    .o_cmd_addr(cmd_addr), .o_cmd_len(cmd_len),
    .o_wr_grant(wr_grant), .o_rd_grant(rd_grant), .i_cmd_done(cmd_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- channel-level model ----------------
  int m_wr_addr [NUM_WR], m_wr_max [NUM_WR], m_wr_len [NUM_WR];
  int m_rd_addr [NUM_RD], m_rd_max [NUM_RD], m_rd_len [NUM_RD];
  int ptr_wr = 0, ptr_rd = 0;
  bit prev_valid = 1'b0;
  bit exp_write = 1'b0;
  int exp_ch = 0, exp_addr = 0, exp_len = 0;
  int exp_wg = 0, exp_rg = 0;

  task automatic model_reload_wr(input int i);
    m_wr_addr[i] = int'(b_wr_start[i]);
    m_wr_max[i]  = int'(b_wr_max[i]);
    m_wr_len[i]  = int'(b_wr_len[i]);
  endtask

  task automatic model_reload_rd(input int j);
    m_rd_addr[j] = int'(b_rd_start[j]);
    m_rd_max[j]  = int'(b_rd_max[j]);
    m_rd_len[j]  = int'(b_rd_len[j]);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_WR; i++) model_reload_wr(i);
    for (int j = 0; j < NUM_RD; j++) model_reload_rd(j);
  endtask

  // Burst finished: advance the granted channel unless it is being reloaded.
  task automatic model_done(input int load_wr);
    if (load_wr >= 0) model_reload_wr(load_wr);
    if (exp_write) begin
      if (exp_ch != load_wr) begin
        int s = m_wr_addr[exp_ch] + m_wr_len[exp_ch];
        m_wr_addr[exp_ch] = (s >= m_wr_max[exp_ch]) ? int'(b_wr_start[exp_ch]) : s;
      end
    end else begin
      int s = m_rd_addr[exp_ch] + m_rd_len[exp_ch];
      m_rd_addr[exp_ch] = (s >= m_rd_max[exp_ch]) ? int'(b_rd_start[exp_ch]) : s;
    end
  endtask

  task automatic model_pick(output bit found);
    found = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bit wr_class = (READ_FIRST == 0) ? (c == 0) : (c == 1);
      if (wr_class) begin
        for (int k = 0; k < NUM_WR; k++) begin
          int i = (ptr_wr + k) % NUM_WR;
          if (!found && m_wr_len[i] != 0 && int'(b_wr_level[i]) >= m_wr_len[i] && !b_wr_load[i]) begin
            found = 1'b1; exp_write = 1'b1; exp_ch = i;
            exp_addr = m_wr_addr[i]; exp_len = m_wr_len[i];
            ptr_wr = (i + 1) % NUM_WR;
          end
        end
      end else begin
        for (int k = 0; k < NUM_RD; k++) begin
          int j = (ptr_rd + k) % NUM_RD;
          if (!found && m_rd_len[j] != 0 && int'(b_rd_level[j]) + m_rd_len[j] <= FIFO_DEPTH && !b_rd_load[j]) begin
            found = 1'b1; exp_write = 1'b0; exp_ch = j;
            exp_addr = m_rd_addr[j]; exp_len = m_rd_len[j];
            ptr_rd = (j + 1) % NUM_RD;
          end
        end
      end
    end
    exp_wg = exp_write ? (1 << exp_ch) : 0;
    exp_rg = exp_write ? 0 : (1 << exp_ch);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      ptr_wr = 0;
      ptr_rd = 0;
      prev_valid = 1'b0;
    end else begin
      if (cmd_valid && !prev_valid) begin
        bit found;
        model_pick(found);
        chk("cmd_has_eligible_channel", found, 1);
      end
      if (cmd_valid) begin
        chk("cmd_write", cmd_write, exp_write);
        chk("cmd_addr", cmd_addr, exp_addr);
        chk("cmd_len", cmd_len, exp_len);
        chk("wr_grant", wr_grant, exp_wg);
        chk("rd_grant", rd_grant, exp_rg);
      end
      prev_valid = cmd_valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_cfg();
    for (int i = 0; i < NUM_WR; i++) begin
      b_wr_level[i] = '0; b_wr_start[i] = '0; b_wr_max[i] = '0; b_wr_len[i] = '0;
    end
    for (int j = 0; j < NUM_RD; j++) begin
      b_rd_level[j] = '0; b_rd_start[j] = '0; b_rd_max[j] = '0; b_rd_len[j] = '0;
    end
    b_wr_load = '0;
    b_rd_load = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_cmd(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (cmd_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL cmd_timeout: no command within 20 cycles at %0t", $time);
    end
  endtask

  task automatic accept(input int hold, input bit tied);
    if (tied) begin
      @(posedge clk); #1;
    end else begin
      repeat (hold) begin
        @(posedge clk); #1;
        chk("valid_held_without_ready", cmd_valid, 1);
      end
      cmd_ready = 1'b1;
      @(posedge clk); #1;
      cmd_ready = 1'b0;
    end
    chk("valid_drops_after_accept", cmd_valid, 0);
  endtask

  task automatic finish(input int load_wr);
    repeat (2) begin
      @(posedge clk); #1;
      chk("wr_grant_busy", wr_grant, exp_wg);
      chk("rd_grant_busy", rd_grant, exp_rg);
    end
    cmd_done = 1'b1;
    if (load_wr >= 0) b_wr_load[load_wr] = 1'b1;
    model_done(load_wr);
    @(posedge clk); #1;
    cmd_done  = 1'b0;
    b_wr_load = '0;
    chk("wr_grant_cleared", wr_grant, 0);
    chk("rd_grant_cleared", rd_grant, 0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bit ok;
    bit seen;
    int t3_addr [4] = '{0, 256, 512, 0};
    int t2_gnt  [4] = '{1, 2, 1, 2};

    clear_cfg();

    // 1: single write channel, reset state and 1-cycle latency
    b_wr_len[0] = 9'd256; b_wr_level[0] = 9'd256; b_wr_start[0] = 0; b_wr_max[0] = 23'd1024;
    do_reset();
    chk("rst_valid", cmd_valid, 0);
    chk("rst_write", cmd_write, 0);
    chk("rst_addr", cmd_addr, 0);
    chk("rst_len", cmd_len, 0);
    chk("rst_wr_grant", wr_grant, 0);
    chk("rst_rd_grant", rd_grant, 0);
    @(posedge clk); #1;
    chk("t1_latency_valid", cmd_valid, 1);
    chk("t1_write", cmd_write, 1);
    chk("t1_addr", cmd_addr, 0);
    chk("t1_len", cmd_len, 256);
    chk("t1_wr_grant", wr_grant, 1);
    accept(0, 1'b0);
    finish(-1);

    // 3: exact landing on the limit wraps
    b_wr_max[0] = 23'd768;
    do_reset();
    for (int b = 0; b < 4; b++) begin
      wait_cmd(ok);
      if (ok) begin
        chk("t3_addr", cmd_addr, t3_addr[b]);
        accept(0, 1'b0);
        finish(-1);
      end
    end

    // 2: two always-eligible writers alternate; eligible reader starves
    clear_cfg();
    b_wr_len[0] = 9'd256; b_wr_level[0] = 9'd256; b_wr_max[0] = 23'd100000;
    b_wr_len[1] = 9'd256; b_wr_level[1] = 9'd256; b_wr_start[1] = 23'd4096; b_wr_max[1] = 23'd100000;
    b_rd_len[0] = 9'd256; b_rd_level[0] = 9'd0;   b_rd_max[0] = 23'd100000;
    cmd_ready = 1'b1;
    do_reset();
    for (int b = 0; b < 4; b++) begin
      wait_cmd(ok);
      if (ok) begin
        chk("t2_wr_grant", wr_grant, t2_gnt[b]);
        chk("t2_rd_grant", rd_grant, 0);
        accept(0, 1'b1);
        finish(-1);
      end
    end
    cmd_ready = 1'b0;

    // 4: read free-space boundary
    clear_cfg();
    b_rd_len[1] = 9'd256; b_rd_level[1] = 9'd256; b_rd_start[1] = 23'd2000; b_rd_max[1] = 23'd100000;
    do_reset();
    wait_cmd(ok);
    if (ok) begin
      chk("t4_write", cmd_write, 0);
      chk("t4_rd_grant", rd_grant, 2);
      chk("t4_addr", cmd_addr, 2000);
      accept(0, 1'b0);
      b_rd_level[1] = 9'd257;
      finish(-1);
    end
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (cmd_valid) seen = 1'b1;
    end
    chk("t4_no_cmd_level_257", seen, 0);
    b_rd_level[1] = 9'd256;
    wait_cmd(ok);
    if (ok) chk("t4_second_addr", cmd_addr, 2256);
    accept(0, 1'b0);
    finish(-1);

    // 5: READY stall, then LOAD together with DONE
    clear_cfg();
    b_wr_len[0] = 9'd50; b_wr_level[0] = 9'd50; b_wr_start[0] = 23'd100; b_wr_max[0] = 23'd10000;
    do_reset();
    wait_cmd(ok);
    if (ok) begin
      chk("t5_addr_first", cmd_addr, 100);
      accept(5, 1'b0);
      b_wr_start[0] = 23'd300;
      finish(0);
    end
    wait_cmd(ok);
    if (ok) begin
      chk("t5_addr_after_load", cmd_addr, 300);
      accept(0, 1'b0);
      finish(-1);
    end

    // 6: reset during BUSY
    clear_cfg();
    b_wr_len[0] = 9'd10; b_wr_level[0] = 9'd10; b_wr_start[0] = 23'd40; b_wr_max[0] = 23'd10000;
    do_reset();
    wait_cmd(ok);
    if (ok) begin
      accept(0, 1'b0);
      finish(-1);
    end
    wait_cmd(ok);
    if (ok) begin
      chk("t6_second_addr", cmd_addr, 50);
      accept(0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
      @(posedge clk); #1;
      chk("t6_rst_valid", cmd_valid, 0);
      chk("t6_rst_wr_grant", wr_grant, 0);
      chk("t6_rst_rd_grant", rd_grant, 0);
      rst = 1'b0;
    end
    wait_cmd(ok);
    if (ok) begin
      chk("t6_addr_after_reset", cmd_addr, 40);
      accept(0, 1'b0);
      finish(-1);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
